// File: rtl/fxp_pkg.sv
// Fixed-point number format and sequencing state encoding shared by the mul and div blocks.
package fxp_pkg;
  localparam int FXP_WIDTH = 24;
  localparam int FXP_FRAC  = 12;
  localparam logic [FXP_WIDTH-2:0] FXP_MAG_MAX = 23'h7FFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DIV    = 3'd2,
    ST_OUT    = 3'd3,
    ST_FINISH = 3'd4
  } fxp_state_t;
endpackage

// File: rtl/fxp_div.sv
// Sign-magnitude fixed-point restoring divider, one quotient bit per clock,
// saturating with err on divide-by-zero or quotient overflow.
//
// state  | meaning
// IDLE   | waiting for en; operands captured on the accepting edge
// LOAD   | unpack signs/magnitudes, clear remainder and iteration count
// DIV    | one compare-subtract iteration per cycle, dividend MSB first
// OUT    | saturate or pack the quotient into out/err
// FINISH | done high for one cycle
module fxp_div
  import fxp_pkg::*;
#(
  parameter int WIDTH = FXP_WIDTH,
  parameter int FRAC  = FXP_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             err
);
  localparam int N  = WIDTH - 1 + FRAC;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  fxp_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sign, dz;
  logic [N-1:0]     d, q;
  logic [WIDTH-2:0] m;
  logic [WIDTH-1:0] r, r_sh;
  logic [CW-1:0]    cnt;
  logic             ge;
  logic             ovf;

  // r stays below m, so its top bit is always clear; folding it into ge keeps
  // the step correct even if that invariant were ever broken.
  assign r_sh = {r[WIDTH-2:0], d[N-1]};
  assign ge   = r[WIDTH-1] | (r_sh >= {1'b0, m});
  assign ovf  = |q[N-1:WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE:   if (en) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_DIV;
      ST_DIV:    if (cnt == LAST) state_d = ST_OUT;
      ST_OUT:    state_d = ST_FINISH;
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      sign <= 1'b0;
      dz   <= 1'b0;
      d    <= '0;
      q    <= '0;
      m    <= '0;
      r    <= '0;
      cnt  <= '0;
      out  <= '0;
      err  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (en) begin
          a_q <= a;
          b_q <= b;
        end
        ST_LOAD: begin
          sign <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
          d    <= {a_q[WIDTH-2:0], {FRAC{1'b0}}};
          m    <= b_q[WIDTH-2:0];
          dz   <= (b_q[WIDTH-2:0] == '0);
          r    <= '0;
          q    <= '0;
          cnt  <= '0;
        end
        ST_DIV: begin
          r   <= ge ? (r_sh - {1'b0, m}) : r_sh;
          q   <= {q[N-2:0], ge};
          d   <= {d[N-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        ST_OUT: begin
          if (dz || ovf) begin
            out <= {sign, {(WIDTH-1){1'b1}}};
            err <= 1'b1;
          end else begin
            out <= {sign, q[WIDTH-2:0]};
            err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fxp_div.sv
// Self-checking bench for fxp_div: arithmetic reference model plus a per-cycle compare process.
module tb_fxp_div;
  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] a_in, b_in;
  logic        en;
  logic [23:0] out;
  logic        done, err;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  typedef struct {
    int          at;
    logic [23:0] val;
    logic        e;
  } exp_t;
  exp_t exp_q[$];
  logic [23:0] last_out = '0;
  logic        last_err = 1'b0;

  fxp_div dut (
    .clk (clk),
    .rst (rst),
    .a   (a_in),
    .b   (b_in),
    .en  (en),
    .out (out),
    .done(done),
    .err (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {err, out} from the plain arithmetic definition of the quotient
  function automatic logic [24:0] model(input logic [23:0] ma, input logic [23:0] mb);
    longint unsigned am, bm, qq;
    logic s;
    am = 64'(ma[22:0]);
    bm = 64'(mb[22:0]);
    s  = ma[23] ^ mb[23];
    if (bm == 0) return {1'b1, s, 23'h7FFFFF};
    qq = (am << 12) / bm;
    if (qq > 64'h7FFFFF) return {1'b1, s, 23'h7FFFFF};
    return {1'b0, s, qq[22:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Caller must be at a negedge. Returns at the negedge where the next start may be driven.
  task automatic issue(input logic [23:0] ta, input logic [23:0] tb_v, input int pulse, input bit noise);
    int k;
    logic [24:0] m;
    a_in = ta;
    b_in = tb_v;
    en   = 1'b1;
    @(negedge clk);
    k = cyc;
    en = 1'b0;
    m = model(ta, tb_v);
    exp_q.push_back('{k + 37, m[23:0], m[24]});
    for (int i = 0; i < 38; i++) begin
      if (i == pulse) begin
        en = 1'b1;
        a_in = 24'h7FF000;
        b_in = 24'h000000;
      end else if (noise) begin
        en = 1'($urandom_range(0, 1));
        a_in = 24'($urandom);
        b_in = 24'($urandom);
      end else begin
        en = 1'b0;
      end
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("result_out", 32'(out), 32'(exp_q[0].val));
        chk("result_err", 32'(err), 32'(exp_q[0].e));
        last_out = exp_q[0].val;
        last_err = exp_q[0].e;
        void'(exp_q.pop_front());
      end else begin
        chk("done_idle", 32'(done), 32'd0);
        chk("out_hold", 32'(out), 32'(last_out));
        chk("err_hold", 32'(err), 32'(last_err));
      end
      if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        errs++;
        $display("FAIL missed_done: expected done at cycle %0d, now %0d", exp_q[0].at, cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst  = 1'b1;
    en   = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("pin_3div2",    32'(model(24'h003000, 24'h002000)), 32'h0001800);
    chk("pin_m3div2",   32'(model(24'h803000, 24'h002000)), 32'h0801800);
    chk("pin_m3divm2",  32'(model(24'h803000, 24'h802000)), 32'h0001800);
    chk("pin_1div3",    32'(model(24'h001000, 24'h003000)), 32'h0000555);
    chk("pin_negzero",  32'(model(24'h001000, 24'h800000)), 32'h1FFFFFF);
    chk("pin_overflow", 32'(model(24'h7FF000, 24'h000001)), 32'h17FFFFF);

    issue(24'h003000, 24'h002000, -1, 1'b0);
    issue(24'h803000, 24'h002000, -1, 1'b0);
    issue(24'h803000, 24'h802000, -1, 1'b0);
    issue(24'h001000, 24'h003000, -1, 1'b0);
    issue(24'h001000, 24'h800000, -1, 1'b0);
    issue(24'h7FF000, 24'h000001, -1, 1'b0);
    issue(24'h800000, 24'h003000, -1, 1'b0);
    issue(24'h7FFFFF, 24'h7FFFFF, -1, 1'b0);
    issue(24'h003000, 24'h002000, 5, 1'b0);

    // abort mid-divide: no done, everything back to zero
    a_in = 24'h7FF000;
    b_in = 24'h000003;
    en   = 1'b1;
    @(negedge clk);
    k  = cyc;
    en = 1'b0;
    while (cyc < k + 10) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    last_out = '0;
    last_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(24'h003000, 24'h002000, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [23:0] ra, rb;
      ra = 24'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 24'($urandom) & 24'h80000F;
        1: rb = 24'($urandom) & 24'h800FFF;
        2: rb = 24'($urandom);
        default: rb = 24'($urandom) & 24'h800000;
      endcase
      issue(ra, rb, -1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
